// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC operation codes,
// exception-level states and the default reset / exception-vector addresses.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JAL    = 3'd3,
    NPC_JALR   = 3'd4,
    NPC_JR     = 3'd5,
    NPC_BNE    = 3'd6,
    NPC_ERET   = 3'd7
  } npc_op_e;

  typedef enum logic {
    EXL_NORMAL  = 1'b0,
    EXL_HANDLER = 1'b1
  } exl_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

  function automatic logic isRegJump(input logic [2:0] op);
    return (op == NPC_JR) || (op == NPC_JALR);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Bundle of controller/ALU-facing signals of the PC unit. The controller side
// drives flow-control inputs (master); the PC unit answers with PC state (slave).
interface pc_unit_if #(
  parameter int WIDTH = 32
);

  logic             stall;
  logic [2:0]       NPCop;
  logic             Zero;
  logic [25:0]      IMM;
  logic [15:0]      Imm16;
  logic [WIDTH-1:0] rs;
  logic             exc_req;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] NPC;
  logic [WIDTH-1:0] link;
  logic [WIDTH-1:0] EPC;
  logic             exl;

  modport master (
    output stall, NPCop, Zero, IMM, Imm16, rs, exc_req,
    input  PC, NPC, link, EPC, exl
  );

  modport slave (
    input  stall, NPCop, Zero, IMM, Imm16, rs, exc_req,
    output PC, NPC, link, EPC, exl
  );

endinterface

// File: rtl/pc_unit_npc_calc.sv
// Purely combinational next-PC computation: sequential, branch, jump,
// register-jump and ERET targets, plus the link address and address-error flag.
module npc_calc
  import pc_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [2:0]       npc_op_i,
  input  logic             zero_i,
  input  logic [25:0]      imm_i,
  input  logic [15:0]      imm16_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] epc_i,
  input  logic             eret_en_i,
  output logic [WIDTH-1:0] npc_o,
  output logic [WIDTH-1:0] link_o,
  output logic             addr_err_o
);

  logic [WIDTH-1:0] pcPlus4;
  logic [WIDTH-1:0] branchOffset;
  logic [WIDTH-1:0] branchTarget;
  logic [WIDTH-1:0] jumpTarget;
  logic [WIDTH-1:0] rsAligned;

  assign pcPlus4      = pc_i + {{(WIDTH-3){1'b0}}, 3'b100};
  assign branchOffset = {{(WIDTH-18){imm16_i[15]}}, imm16_i, 2'b00};
  assign branchTarget = pcPlus4 + branchOffset;
  assign jumpTarget   = {pcPlus4[WIDTH-1:28], imm_i, 2'b00};
  // Low bits are always dropped; a misaligned target is reported separately
  assign rsAligned    = {rs_i[WIDTH-1:2], 2'b00};

  assign link_o     = pcPlus4;
  assign addr_err_o = isRegJump(npc_op_i) && (rs_i[1:0] != 2'b00);

  always_comb begin
    npc_o = pcPlus4;
    case (npc_op_i)
      NPC_PLUS4:  npc_o = pcPlus4;
      NPC_BRANCH: npc_o = zero_i ? branchTarget : pcPlus4;
      NPC_BNE:    npc_o = zero_i ? pcPlus4 : branchTarget;
      NPC_JUMP:   npc_o = jumpTarget;
      NPC_JAL:    npc_o = jumpTarget;
      NPC_JALR:   npc_o = rsAligned;
      NPC_JR:     npc_o = rsAligned;
      NPC_ERET:   npc_o = eret_en_i ? epc_i : pcPlus4;
      default:    npc_o = pcPlus4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection, stall and link output.
// Define PC_UNIT_EXC_EN to add the exception/ERET path with EPC and exl state.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
  input logic       clk,
  input logic       rstn,
  pc_unit_if.slave  bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] linkAddr;
  logic             addrErr;

`ifdef PC_UNIT_EXC_EN

  logic [WIDTH-1:0] epc_q;
  exl_state_e       exl_q;

  npc_calc #(
    .WIDTH (WIDTH)
  ) u_npc_calc (
    .pc_i       (pc_q),
    .npc_op_i   (bus.NPCop),
    .zero_i     (bus.Zero),
    .imm_i      (bus.IMM),
    .imm16_i    (bus.Imm16),
    .rs_i       (bus.rs),
    .epc_i      (epc_q),
    .eret_en_i  (exl_q == EXL_HANDLER),
    .npc_o      (pc_d),
    .link_o     (linkAddr),
    .addr_err_o (addrErr)
  );

  // Exception entry beats stall; inside the handler requests and address
  // errors are masked and only a non-stalled ERET leaves it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
      exl_q <= EXL_NORMAL;
    end else begin
      case (exl_q)
        EXL_NORMAL: begin
          if (bus.exc_req || addrErr) begin
            pc_q  <= EXC_VECTOR;
            epc_q <= pc_q;
            exl_q <= EXL_HANDLER;
          end else if (!bus.stall) begin
            pc_q <= pc_d;
          end
        end
        EXL_HANDLER: begin
          if (!bus.stall) begin
            pc_q <= pc_d;
            if (bus.NPCop == NPC_ERET) begin
              exl_q <= EXL_NORMAL;
            end
          end
        end
        default: begin
          exl_q <= EXL_NORMAL;
        end
      endcase
    end
  end

  assign bus.EPC = epc_q;
  assign bus.exl = (exl_q == EXL_HANDLER);

`else

  logic unusedExcReq;
  logic unusedAddrErr;

  npc_calc #(
    .WIDTH (WIDTH)
  ) u_npc_calc (
    .pc_i       (pc_q),
    .npc_op_i   (bus.NPCop),
    .zero_i     (bus.Zero),
    .imm_i      (bus.IMM),
    .imm16_i    (bus.Imm16),
    .rs_i       (bus.rs),
    .epc_i      ({WIDTH{1'b0}}),
    .eret_en_i  (1'b0),
    .npc_o      (pc_d),
    .link_o     (linkAddr),
    .addr_err_o (addrErr)
  );

  // Without the exception path a misaligned register jump simply lands on
  // the aligned address that npc_calc already produces.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
    end else if (!bus.stall) begin
      pc_q <= pc_d;
    end
  end

  assign unusedExcReq  = bus.exc_req;
  assign unusedAddrErr = addrErr;
  assign bus.EPC       = '0;
  assign bus.exl       = 1'b0;

`endif

  assign bus.PC   = pc_q;
  assign bus.NPC  = pc_d;
  assign bus.link = linkAddr;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver pushes reference-model expectations,
// an independent monitor compares NPC/link and the post-edge PC/EPC/exl.
module tb_pc_unit;

  localparam int          WIDTH      = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
`ifdef PC_UNIT_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  typedef struct {
    bit          checkComb;
    logic [31:0] npc;
    logic [31:0] link;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exl;
  } expect_t;

  expect_t sbQ[$];
  int compared   = 0;
  int mismatched = 0;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(WIDTH)) bus();

  pc_unit #(
    .WIDTH      (WIDTH),
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Reference model state, updated directly from the architectural rules
  logic [31:0] mPc  = 32'h0;
  logic [31:0] mEpc = 32'h0;
  bit          mExl = 1'b0;
  bit          mValid = 1'b0;

  function automatic logic [31:0] modelNext(input int op, input bit zero,
                                            input logic [25:0] imm,
                                            input logic [15:0] imm16,
                                            input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = mPc + 32'd4;
    off = 4 * int'($signed(imm16));
    case (op)
      1:       return zero ? seq + 32'(off) : seq;
      6:       return zero ? seq : seq + 32'(off);
      2, 3:    return (seq & 32'hF000_0000) + ({6'b0, imm} * 32'd4);
      4, 5:    return rs - (rs % 32'd4);
      7:       return (EXC_EN && mExl) ? mEpc : seq;
      default: return seq;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit stall, input int op,
                               input bit zero, input logic [25:0] imm,
                               input logic [15:0] imm16, input logic [31:0] rs,
                               input bit exc);
    expect_t     e;
    logic [31:0] target;
    bit          misaligned;
    @(negedge clk);
    rstn        = ~rst;
    bus.stall   = stall;
    bus.NPCop   = 3'(op);
    bus.Zero    = zero;
    bus.IMM     = imm;
    bus.Imm16   = imm16;
    bus.rs      = rs;
    bus.exc_req = exc;
    target      = modelNext(op, zero, imm, imm16, rs);
    misaligned  = (op == 4 || op == 5) && (rs % 32'd4 != 0);
    e.checkComb = mValid;
    e.npc       = target;
    e.link      = mPc + 32'd4;
    if (rst) begin
      mPc = RESET_PC; mEpc = 32'h0; mExl = 1'b0; mValid = 1'b1;
    end else if (EXC_EN && !mExl && (exc || misaligned)) begin
      mEpc = mPc; mPc = EXC_VECTOR; mExl = 1'b1;
    end else if (!stall) begin
      if (op == 7 && EXC_EN && mExl) mExl = 1'b0;
      mPc = target;
    end
    e.pc  = mPc;
    e.epc = mEpc;
    e.exl = mExl;
    if (mValid) sbQ.push_back(e);
  endtask

  task automatic jumpTo(input logic [31:0] addr);
    applyStimulus(0, 0, 2, 0, addr[27:2], 16'h0, 32'h0, 0);
  endtask

  // Monitor: combinational outputs mid-cycle, registered state after the edge
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbQ.size() > 0) begin
        e = sbQ[0];
        if (e.checkComb) begin
          checkOutput("NPC", bus.NPC, e.npc);
          checkOutput("link", bus.link, e.link);
        end
        @(posedge clk);
        #1;
        checkOutput("PC", bus.PC, e.pc);
        checkOutput("EPC", bus.EPC, e.epc);
        checkOutput("exl", {31'b0, bus.exl}, {31'b0, e.exl});
        e = sbQ.pop_front();
      end
    end
  end

  initial begin
    logic [31:0] rs;
    rstn = 1'b0;
    bus.stall = 1'b0; bus.NPCop = 3'd0; bus.Zero = 1'b0; bus.IMM = '0;
    bus.Imm16 = '0; bus.rs = '0; bus.exc_req = 1'b0;

    applyStimulus(1, 0, 0, 0, 26'h0, 16'h0, 32'h0, 0);
    applyStimulus(1, 0, 0, 0, 26'h0, 16'h0, 32'h0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 0);

    jumpTo(32'h0000_3010);
    applyStimulus(0, 0, 1, 1, 26'h0, 16'hFFFF, 32'h0, 0);
    applyStimulus(0, 0, 1, 0, 26'h0, 16'hFFFF, 32'h0, 0);
    jumpTo(32'h0000_3010);
    applyStimulus(0, 0, 6, 0, 26'h0, 16'hFFFF, 32'h0, 0);
    applyStimulus(0, 0, 6, 1, 26'h0, 16'hFFFF, 32'h0, 0);
    applyStimulus(0, 0, 1, 1, 26'h0, 16'h0008, 32'h0, 0);

    jumpTo(32'h0000_3020);
    applyStimulus(0, 0, 3, 0, 26'h0000C40, 16'h0, 32'h0, 0);
    applyStimulus(0, 0, 5, 0, 26'h0, 16'h0, 32'h0000_3024, 0);

    jumpTo(32'h0000_3040);
    applyStimulus(0, 1, 0, 0, 26'h0, 16'h0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 1);
    applyStimulus(0, 0, 7, 0, 26'h0, 16'h0, 32'h0, 1);
    applyStimulus(0, 0, 7, 0, 26'h0, 16'h0, 32'h0, 0);

    jumpTo(32'h0000_3060);
    applyStimulus(0, 0, 5, 0, 26'h0, 16'h0, 32'h0000_3002, 0);
    applyStimulus(0, 0, 7, 0, 26'h0, 16'h0, 32'h0, 0);

    repeat (4) applyStimulus(0, 1, 2, 0, 26'h0000C80, 16'h0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 1);
    applyStimulus(1, 0, 0, 0, 26'h0, 16'h0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 0);

    for (int i = 0; i < 1500; i++) begin
      rs = $urandom;
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                    26'($urandom), 16'($urandom), rs,
                    ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(negedge clk);
    compared++;
    if (sbQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
